// File: rtl/minuend_restorer_if.sv
// Operand/result bundle for minuend_restorer: operand handshake in, result handshake out.
// master = producer/consumer side, slave = the restorer itself.
interface minuend_restorer_if #(
  parameter int WIDTH = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             sign;
  logic [WIDTH-1:0] subtrahend;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] minuend;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, diff, sign, subtrahend, out_ready,
    input  in_ready, out_valid, minuend, err, busy
  );

  modport slave (
    input  in_valid, diff, sign, subtrahend, out_ready,
    output in_ready, out_valid, minuend, err, busy
  );
endinterface

// File: rtl/minuend_restorer.sv
// Bit-serial restorer: minuend = diff + subtrahend, result WIDTH+1 clocks after acceptance, held until out_ready.
// One operand set in flight (in_ready only in IDLE); RESTORE_CHECK_EN enables the carry-vs-sign err check.
module minuend_restorer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  minuend_restorer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q,   state_d;
  logic [WIDTH-1:0] d_q,       d_d;
  logic [WIDTH-1:0] s_q,       s_d;
  logic [WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0] minuend_q, minuend_d;
  logic             carry_q,   carry_d;
  logic [CW-1:0]    cnt_q,     cnt_d;

  logic             sum_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_word;
  logic             last_bit;

  // Operands shift right so bit 0 is always the one being added; sums enter acc from the MSB end.
  assign sum_bit   = d_q[0] ^ s_q[0] ^ carry_q;
  assign carry_nxt = (d_q[0] & s_q[0]) | (d_q[0] & carry_q) | (s_q[0] & carry_q);
  assign sum_word  = {sum_bit, acc_q[WIDTH-1:1]};
  assign last_bit  = (cnt_q == LAST_BIT);

`ifdef RESTORE_CHECK_EN
  logic sign_q, sign_d;
  logic err_q,  err_d;
`endif

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    s_d       = s_q;
    acc_d     = acc_q;
    minuend_d = minuend_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
`ifdef RESTORE_CHECK_EN
    sign_d    = sign_q;
    err_d     = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          d_d     = bus.diff;
          s_d     = bus.subtrahend;
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef RESTORE_CHECK_EN
          sign_d  = bus.sign;
`endif
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        d_d     = d_q >> 1;
        s_d     = s_q >> 1;
        acc_d   = sum_word;
        carry_d = carry_nxt;
        if (last_bit) begin
          // Counter parks on the last index rather than wrapping.
          minuend_d = sum_word;
`ifdef RESTORE_CHECK_EN
          err_d     = (carry_nxt == sign_q);
`endif
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      d_q       <= '0;
      s_q       <= '0;
      acc_q     <= '0;
      minuend_q <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      s_q       <= s_d;
      acc_q     <= acc_d;
      minuend_q <= minuend_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef RESTORE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sign_q <= sign_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_ADD) || (state_q == ST_DONE);
  assign bus.minuend   = minuend_q;

endmodule

// File: tb/tb_minuend_restorer.sv
// Directed bench for minuend_restorer at WIDTH=2 and WIDTH=8; err expectations follow RESTORE_CHECK_EN.
module tb_minuend_restorer;

`ifdef RESTORE_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  minuend_restorer_if #(.WIDTH(2)) b2 ();
  minuend_restorer_if #(.WIDTH(8)) b8 ();

  minuend_restorer #(.WIDTH(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  minuend_restorer #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full WIDTH=2 transaction with out_ready=1; inputs are scrambled after acceptance.
  task automatic run_txn(input string tag, input logic [1:0] d, input logic s,
                         input logic [1:0] b, input logic [1:0] exp_m, input logic exp_e);
    b2.in_valid   = 1'b1;
    b2.diff       = d;
    b2.sign       = s;
    b2.subtrahend = b;
    b2.out_ready  = 1'b1;
    tick();
    chk({tag, ".busy1"}, b2.busy, 1);
    chk({tag, ".in_ready1"}, b2.in_ready, 0);
    chk({tag, ".out_valid1"}, b2.out_valid, 0);
    b2.in_valid   = 1'b0;
    b2.diff       = ~d;
    b2.sign       = ~s;
    b2.subtrahend = ~b;
    tick();
    chk({tag, ".out_valid2"}, b2.out_valid, 0);
    tick();
    chk({tag, ".out_valid3"}, b2.out_valid, 1);
    chk({tag, ".minuend"}, b2.minuend, exp_m);
    chk({tag, ".err"}, b2.err, exp_e & CHK_EN);
    tick();
    chk({tag, ".in_ready_after"}, b2.in_ready, 1);
    chk({tag, ".out_valid_after"}, b2.out_valid, 0);
    chk({tag, ".minuend_held"}, b2.minuend, exp_m);
  endtask

  logic [1:0] st_d   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
  logic [1:0] st_b   [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
  logic       st_s   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] st_m   [4] = '{2'd1, 2'd3, 2'd1, 2'd2};
  logic       st_e   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;

    // Reset with in_valid asserted: must be ignored.
    rst = 1'b1;
    b2.in_valid = 1'b1; b2.diff = 2'd3; b2.sign = 1'b1; b2.subtrahend = 2'd3; b2.out_ready = 1'b0;
    b8.in_valid = 1'b0; b8.diff = '0;   b8.sign = 1'b0; b8.subtrahend = '0;   b8.out_ready = 1'b1;
    tick();
    tick();
    chk("rst.in_ready", b2.in_ready, 1);
    chk("rst.out_valid", b2.out_valid, 0);
    chk("rst.busy", b2.busy, 0);
    chk("rst.minuend", b2.minuend, 0);
    chk("rst.err", b2.err, 0);
    chk("rst.in_ready8", b8.in_ready, 1);
    chk("rst.minuend8", b8.minuend, 0);
    b2.in_valid = 1'b0;
    rst = 1'b0;

    // 3 + 2 = 5 -> 01, carry 1 vs sign 0
    run_txn("basic", 2'b11, 1'b0, 2'b10, 2'b01, 1'b0);
    // 1 + 1 = 2 -> 10, carry 0
    run_txn("sign1", 2'b01, 1'b1, 2'b01, 2'b10, 1'b0);
    run_txn("sign0", 2'b01, 1'b0, 2'b01, 2'b10, 1'b1);

    // Back-pressure: 2 + 3 = 5 -> 01, carry 1 == sign 1
    b2.in_valid = 1'b1; b2.diff = 2'b10; b2.sign = 1'b1; b2.subtrahend = 2'b11; b2.out_ready = 1'b0;
    tick();
    b2.in_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", b2.out_valid, 1);
      chk("bp.minuend", b2.minuend, 2'b01);
      chk("bp.err", b2.err, CHK_EN);
      chk("bp.in_ready", b2.in_ready, 0);
      tick();
    end
    chk("bp.still_valid", b2.out_valid, 1);
    b2.out_ready = 1'b1;
    tick();
    chk("bp.released_in_ready", b2.in_ready, 1);
    chk("bp.released_out_valid", b2.out_valid, 0);

    // Reset on the first ADD cycle discards the partial result.
    b2.in_valid = 1'b1; b2.diff = 2'b01; b2.sign = 1'b0; b2.subtrahend = 2'b01;
    tick();
    chk("midrst.busy_before", b2.busy, 1);
    b2.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.in_ready", b2.in_ready, 1);
    chk("midrst.out_valid", b2.out_valid, 0);
    chk("midrst.busy", b2.busy, 0);
    chk("midrst.minuend", b2.minuend, 0);
    chk("midrst.err", b2.err, 0);
    // 0 + 3 = 3, carry 0 vs sign 1
    run_txn("postrst", 2'b00, 1'b1, 2'b11, 2'b11, 1'b0);

    // Streaming: one result every 4 clocks, in order.
    b2.out_ready = 1'b1;
    b2.in_valid = 1'b1; b2.diff = st_d[0]; b2.sign = st_s[0]; b2.subtrahend = st_b[0];
    for (int c = 0; c < 16; c++) begin
      tick();
      if (c % 4 == 0) begin
        if (c / 4 < 3) begin
          b2.diff = st_d[c/4 + 1]; b2.sign = st_s[c/4 + 1]; b2.subtrahend = st_b[c/4 + 1];
        end else begin
          b2.in_valid = 1'b0;
        end
      end
      chk("stream.out_valid", b2.out_valid, (c % 4 == 2) ? 1 : 0);
      chk("stream.in_ready", b2.in_ready, (c % 4 == 3) ? 1 : 0);
      if (c % 4 == 2) begin
        chk("stream.minuend", b2.minuend, st_m[c/4]);
        chk("stream.err", b2.err, st_e[c/4] & CHK_EN);
      end
    end

    // WIDTH=8: FF + 01 = 100 -> 00, carry 1 vs sign 0, 8 ADD cycles.
    b8.in_valid = 1'b1; b8.diff = 8'hFF; b8.sign = 1'b0; b8.subtrahend = 8'h01; b8.out_ready = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    n = 0;
    while (b8.out_valid !== 1'b1 && n < 20) begin
      chk("w8.busy", b8.busy, 1);
      tick();
      n++;
    end
    chk("w8.latency", n, 8);
    chk("w8.minuend", b8.minuend, 8'h00);
    chk("w8.err", b8.err, 0);
    tick();
    chk("w8.in_ready_after", b8.in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/minuend_restorer.md
MINUEND_RESTORER -- requirements
Module: minuend_restorer

Interface
REQ-001 Parameter: WIDTH, default 2, operand width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 diff  input  WIDTH  difference word produced by a two's-complement subtraction a - b.
REQ-007 sign  input  1  subtractor carry-out paired with diff.
REQ-008 subtrahend  input  WIDTH  the b operand of that subtraction.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 minuend  output  WIDTH  restored operand, (diff + subtrahend) mod 2^WIDTH.
REQ-012 err  output  1  consistency failure between the final carry and sign.
REQ-013 busy  output  1  high in ADD and DONE states.

Function
REQ-014 FSM states: IDLE, ADD, DONE; IDLE is the only state with in_ready=1.
REQ-015 IDLE: on in_valid=1, capture diff, subtrahend and sign into internal registers, clear carry and bit counter, go to ADD.
REQ-016 ADD: one bit per clock, LSB first; sum bit = d[i] ^ s[i] ^ carry; carry <= majority(d[i], s[i], carry); bit counter increments.
REQ-017 ADD lasts exactly WIDTH clocks; on the edge that processes bit WIDTH-1, load minuend and err registers and go to DONE.
REQ-018 err = 1 when the carry out of bit WIDTH-1 equals the captured sign, else 0.
REQ-019 DONE: out_valid=1; minuend and err stay stable while out_ready=0.
REQ-020 DONE with out_ready=1: handshake completes, go to IDLE on that edge; in_ready is 0 in the DONE cycle, so no overlapping acceptance.
REQ-021 Latency: acceptance edge k, out_valid high in the cycle after edge k+WIDTH; back-to-back throughput is one result per WIDTH+2 clocks.
REQ-022 Input ports are sampled only on the acceptance edge; changes during ADD or DONE have no effect.
REQ-023 minuend and err hold their last value in IDLE until overwritten by the next completed ADD.
REQ-024 The bit counter is ceil(log2(WIDTH)) bits wide (minimum 1) and never wraps inside ADD.

Reset
REQ-025 rst=1 on a clock edge forces: state IDLE, in_ready=1, out_valid=0, busy=0, minuend=0, err=0, carry=0, counter=0.
REQ-026 Reset takes priority over every transition, including mid-ADD and an in-progress DONE handshake; any partial result is discarded.
REQ-027 in_valid during a reset cycle is ignored; the first acceptance can occur on the first edge with rst=0.

Configuration
REQ-028 Macro RESTORE_CHECK_EN: when defined, err behaves per REQ-018.
REQ-029 When RESTORE_CHECK_EN is undefined, err is tied to 0, the sign register and compare logic are absent, and the port list is unchanged.

Verification (WIDTH=2, RESTORE_CHECK_EN defined unless noted)
REQ-030 diff=2'b11, sign=0, subtrahend=2'b10, out_ready=1 -> minuend=2'b01, err=0, out_valid high in the 3rd cycle after acceptance.
REQ-031 diff=2'b01, sign=1, subtrahend=2'b01 -> minuend=2'b10, err=0; repeat with sign=0 -> minuend=2'b10, err=1; with the macro undefined -> err=0.
REQ-032 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1, minuend and err unchanged, in_ready=0 throughout; the result completes on the first out_ready=1 edge.
REQ-033 rst=1 on the 1st ADD cycle -> next cycle: state IDLE, out_valid=0, minuend=2'b00, in_ready=1; a new transaction then completes correctly.
REQ-034 in_valid=1 and out_ready=1 held continuously with 4 operand sets -> 4 results, one per 4 clocks, in input order.
REQ-035 WIDTH=8: diff=8'hFF, sign=0, subtrahend=8'h01 -> minuend=8'h00, err=0, latency 8 ADD cycles.
